// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM readback checker, its stimulus FSM and benches.
package lutram_test_pkg;

  localparam int A_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_e;

  // Data bit written to each address during the fill phase.
  function automatic logic pattern(input logic [A_WIDTH_DEF-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/lutram_readback_checker_if.sv
// Snoop bus between the LUTRAM stimulus/DUT side and the readback checker.
interface lutram_readback_checker_if #(
  parameter int A_WIDTH = lutram_test_pkg::A_WIDTH_DEF
) ();

  logic               we;
  logic [A_WIDTH-1:0] waddr;
  logic               wdata;
  logic               rd_valid;
  logic [A_WIDTH-1:0] dpra;
  logic               rd_last;
  logic               spo;
  logic               dpo;

  modport master (
    output we, waddr, wdata, rd_valid, dpra, rd_last, spo, dpo
  );

  modport slave (
    input we, waddr, wdata, rd_valid, dpra, rd_last, spo, dpo
  );

endinterface

// File: rtl/lutram_readback_checker_shadow_mem.sv
// Bit-exact shadow of the LUTRAM: one synchronous write port, two
// combinational read ports that return the pre-write contents.
module lutram_shadow_mem
  import lutram_test_pkg::*;
#(
  parameter int                       A_WIDTH = A_WIDTH_DEF,
  parameter logic [(2**A_WIDTH)-1:0] INIT    = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic               wdata_i,
  input  logic [A_WIDTH-1:0] raddr_a_i,
  input  logic [A_WIDTH-1:0] raddr_b_i,
  output logic               rdata_a_o,
  output logic               rdata_b_o
);

  logic [(2**A_WIDTH)-1:0] mem_q;

  // Shadow array: reset restores INIT so it tracks a reconfigured DUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= INIT;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lutram_readback_checker.sv
// Compares LUTRAM SPO/DPO readback against a snooped shadow copy and
// reports sticky error, saturating count, first failure and done/pass.
//
// state    | meaning
// ST_IDLE  | waiting for the first accepted check
// ST_CHECK | checks in flight, final one not yet processed
// ST_DONE  | final check processed; further checks ignored until clear
module lutram_readback_checker
  import lutram_test_pkg::*;
#(
  parameter int                       A_WIDTH = A_WIDTH_DEF,
  parameter int                       CNT_W   = 8,
  parameter logic [(2**A_WIDTH)-1:0] INIT    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  lutram_readback_checker_if.slave  bus_if,
  output logic                      err_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic [A_WIDTH-1:0]        first_err_addr_o,
  output logic [1:0]                first_err_port_o,
  output logic                      done_o,
  output logic                      pass_o
);

  chk_state_e         state_q, state_d;
  logic               exp_spo, exp_dpo;
  logic               accept;

  logic               v_q, v_d;
  logic               spo_q, dpo_q, exp_spo_q, exp_dpo_q, last_q;
  logic [A_WIDTH-1:0] addr_q;

  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] faddr_q, faddr_d;
  logic [1:0]         fport_q, fport_d;
  logic [1:0]         mis;
  logic               hit;

  lutram_shadow_mem #(
    .A_WIDTH (A_WIDTH),
    .INIT    (INIT)
  ) u_shadow (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (bus_if.we),
    .waddr_i   (bus_if.waddr),
    .wdata_i   (bus_if.wdata),
    .raddr_a_i (bus_if.waddr),
    .raddr_b_i (bus_if.dpra),
    .rdata_a_o (exp_spo),
    .rdata_b_o (exp_dpo)
  );

  assign accept = bus_if.rd_valid && (state_q != ST_DONE);
  assign v_d    = accept && !clr_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; clear wins over any in-flight completion.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_CHECK;
        ST_CHECK: if (v_q && last_q) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Stage 1: capture DUT outputs with the read-before-write expectations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q       <= 1'b0;
      spo_q     <= 1'b0;
      dpo_q     <= 1'b0;
      exp_spo_q <= 1'b0;
      exp_dpo_q <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      v_q <= v_d;
      if (accept) begin
        spo_q     <= bus_if.spo;
        dpo_q     <= bus_if.dpo;
        exp_spo_q <= exp_spo;
        exp_dpo_q <= exp_dpo;
        last_q    <= bus_if.rd_last;
        addr_q    <= bus_if.waddr;
      end
    end
  end

  assign mis = {dpo_q ^ exp_dpo_q, spo_q ^ exp_spo_q};
  assign hit = v_q && (mis != 2'b00);

  // Stage 2 result update; first-failure fields latch only while err is clear.
  always_comb begin
    err_d   = err_q;
    cnt_d   = cnt_q;
    faddr_d = faddr_q;
    fport_d = fport_q;
    if (clr_i) begin
      err_d   = 1'b0;
      cnt_d   = '0;
      faddr_d = '0;
      fport_d = 2'b00;
    end else if (hit) begin
      err_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (!err_q) begin
        faddr_d = addr_q;
        fport_d = mis;
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
      fport_q <= 2'b00;
    end else begin
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      faddr_q <= faddr_d;
      fport_q <= fport_d;
    end
  end

  assign err_o            = err_q;
  assign err_cnt_o        = cnt_q;
  assign first_err_addr_o = faddr_q;
  assign first_err_port_o = fport_q;
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = done_o && !err_q;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Scoreboard bench: a behavioural shadow model predicts each run's final
// result; a monitor compares when done_o rises. A second checker instance
// with a 2-bit counter watches the same bus to exercise saturation.
module tb_lutram_readback_checker;
  import lutram_test_pkg::*;

  localparam int AW    = 7;
  localparam int DEPTH = 2**AW;

  typedef struct {
    bit err;
    int cnt;
    int faddr;
    int fport;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic          err_o, sat_err_o;
  logic [7:0]    err_cnt_o;
  logic [1:0]    sat_cnt_o;
  logic [AW-1:0] first_err_addr_o, sat_faddr_o;
  logic [1:0]    first_err_port_o, sat_fport_o;
  logic          done_o, sat_done_o, pass_o, sat_pass_o;

  lutram_readback_checker_if #(.A_WIDTH(AW)) bus ();

  lutram_readback_checker #(.A_WIDTH(AW), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus_if(bus),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .first_err_port_o(first_err_port_o), .done_o(done_o), .pass_o(pass_o)
  );

  lutram_readback_checker #(.A_WIDTH(AW), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus_if(bus),
    .err_o(sat_err_o), .err_cnt_o(sat_cnt_o), .first_err_addr_o(sat_faddr_o),
    .first_err_port_o(sat_fport_o), .done_o(sat_done_o), .pass_o(sat_pass_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  res_t exp_q[$];

  bit   ref_mem[DEPTH];
  bit   m_err, m_done;
  int   m_cnt, m_faddr, m_fport;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_clear_stats();
    m_err = 0; m_done = 0; m_cnt = 0; m_faddr = 0; m_fport = 0;
  endtask

  // One bus cycle; the bench plays the role of a correct LUTRAM, optionally
  // corrupting SPO/DPO, and the model scores each accepted check.
  task automatic step(input bit we, input int wa, input bit wd, input bit rv,
                      input int da, input bit last, input bit fs, input bit fd);
    bit es, ed;
    res_t r;
    @(negedge clk);
    es = ref_mem[wa % DEPTH];
    ed = ref_mem[da % DEPTH];
    bus.we       = we;
    bus.waddr    = AW'(wa);
    bus.wdata    = wd;
    bus.rd_valid = rv;
    bus.dpra     = AW'(da);
    bus.rd_last  = last;
    bus.spo      = es ^ fs;
    bus.dpo      = ed ^ fd;
    @(posedge clk);
    if (rv && !m_done) begin
      if (fs || fd) begin
        if (!m_err) begin
          m_faddr = wa % DEPTH;
          m_fport = {30'd0, fd, fs};
        end
        m_err = 1;
        m_cnt++;
      end
      if (last) begin
        m_done = 1;
        r.err = m_err; r.cnt = m_cnt; r.faddr = m_faddr; r.fport = m_fport;
        exp_q.push_back(r);
      end
    end
    if (we) ref_mem[wa % DEPTH] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_end(input string name);
    idle(4);
    chk({name, "_done_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_err"}, err_o, 0);
    chk({name, "_cnt"}, err_cnt_o, 0);
    chk({name, "_faddr"}, first_err_addr_o, 0);
    chk({name, "_fport"}, first_err_port_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_pass"}, pass_o, 0);
  endtask

  task automatic do_clear(input string name);
    @(negedge clk);
    clr = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear_stats();
    @(negedge clk);
    clr = 1'b0;
    #1 check_zero(name);
  endtask

  task automatic read_all(input int fault_a, input bit fs_a, input bit fd_a,
                          input int fault_b, input bit fs_b, input bit fd_b);
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 0, 0, 1, a, 0, 0, 0);
    end
  endtask

  // Scoreboard monitor: on each rising done_o, pop and compare the prediction.
  bit done_prev = 0;
  always @(negedge clk) begin
    res_t e;
    if (rst_n && done_o && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("err", err_o, e.err);
        chk("err_cnt", err_cnt_o, (e.cnt > 255) ? 255 : e.cnt);
        chk("first_err_addr", first_err_addr_o, e.faddr);
        chk("first_err_port", first_err_port_o, e.fport);
        chk("pass", pass_o, !e.err);
        chk("sat_done", sat_done_o, 1);
        chk("sat_err", sat_err_o, e.err);
        chk("sat_cnt", sat_cnt_o, (e.cnt > 3) ? 3 : e.cnt);
        chk("sat_first_err", {sat_fport_o, sat_faddr_o}, {e.fport[1:0], e.faddr[AW-1:0]});
        chk("sat_pass", sat_pass_o, !e.err);
      end
    end
    done_prev = done_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we = 0; bus.waddr = '0; bus.wdata = 0; bus.rd_valid = 0;
    bus.dpra = '0; bus.rd_last = 0; bus.spo = 0; bus.dpo = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    model_clear_stats();

    #12 check_zero("reset");
    chk("reset_sat_cnt", sat_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run: fill with the pattern, stray rd_last alone, read back all.
    for (int a = 0; a < DEPTH; a++) step(1, a, pattern(AW'(a)), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    for (int a = 0; a < DEPTH; a++) step(0, a, 0, 1, a, a == DEPTH-1, 0, 0);
    run_end("clean");

    // Clear in DONE keeps the shadow: a re-read with no writes still passes.
    do_clear("clr_done");
    for (int a = 0; a < DEPTH; a++) step(0, a, 0, 1, DEPTH-1-a, a == DEPTH-1, 0, 0);
    run_end("reread");

    do_clear("clr1");
    for (int a = 0; a < DEPTH; a++) step(0, a, 0, 1, a, a == DEPTH-1, a == 37, 0);
    run_end("spo_fault");

    do_clear("clr2");
    for (int a = 0; a < DEPTH; a++)
      step(0, a, 0, 1, a, a == DEPTH-1, a == 5, (a == 5) || (a == 90));
    run_end("dual_fault");

    // Same-cycle write to the read address compares against the old bit.
    do_clear("clr3");
    step(1, 10, 1, 1, 10, 0, 0, 0);
    step(0, 10, 0, 1, 10, 1, 0, 0);
    run_end("rbw");

    do_clear("clr4");
    for (int i = 0; i < 6; i++) step(0, i * 7, 0, 1, i * 3, i == 5, 1, i[0]);
    run_end("saturate");

    for (int r = 0; r < 3; r++) begin
      do_clear("clr_rand");
      for (int i = 0; i < 60; i++) begin
        bit rv;
        rv = (i == 59) ? 1'b1 : 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)),
             rv, $urandom_range(0, DEPTH-1), i == 59,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
      run_end("random");
    end

    // Async reset mid-CHECK with an error already recorded.
    do_clear("clr5");
    for (int a = 0; a < 16; a++) step(1, a, 1, 0, 0, 0, 0, 0);
    step(0, 3, 0, 1, 4, 0, 1, 0);
    step(0, 5, 0, 1, 6, 0, 0, 0);
    idle(1);
    chk("pre_reset_err", err_o, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    model_clear_stats();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) step(0, a, 0, 1, 15-a, a == 15, 0, 0);
    run_end("post_reset");

    // Empty run: stray rd_last without rd_valid must never complete.
    do_clear("clr6");
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), i, 0, 0, i, 1, 0, 0);
    idle(3);
    chk("empty_run_done", done_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
